// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction buffer between fetch and decode. Holds {pc, instr, pred_pc,
// pred_taken} tuples in a DEPTH-entry first-word-fall-through FIFO so that
// fetch can keep running while decode stalls. An execute-stage mispredict
// (flush) empties the queue in one cycle. The head entry is flagged as
// illegal when its low two bits do not mark a 32-bit encoding.
//
// Parameters
//   DEPTH          number of entries (power of two, >= 2)
//   PC_W           PC width in bits
//
// Ports
//   clk            clock, all state updates on the rising edge
//   n_reset        asynchronous active-low reset
//   flush          mispredict redirect; discards all contents
//   in_valid       fetch presents a tuple
//   in_ready       queue has room (count != DEPTH)
//   in_pc          PC of the fetched instruction
//   in_instr       fetched instruction word
//   in_pred_pc     predicted next PC
//   in_pred_taken  predictor redirected
//   out_valid      head entry is valid (count != 0)
//   out_ready      decode accepts the head this cycle
//   out_pc         head PC
//   out_instr      head instruction word
//   out_pred_pc    head predicted next PC
//   out_pred_taken head prediction flag
//   out_illegal    head instr[1:0] != 2'b11
//   count          current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 48
) (
    input  logic                         clk,
    input  logic                         n_reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PC_W-1:0]              in_pc,
    input  logic [31:0]                  in_instr,
    input  logic [PC_W-1:0]              in_pred_pc,
    input  logic                         in_pred_taken,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PC_W-1:0]              out_pc,
    output logic [31:0]                  out_instr,
    output logic [PC_W-1:0]              out_pred_pc,
    output logic                         out_pred_taken,
    output logic                         out_illegal,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
        logic [PC_W-1:0] pred_pc;
        logic            pred_taken;
    } entry_t;

    entry_t           entries [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] rp;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;

    // Handshake signals depend only on registered occupancy, so there is
    // no combinational path from in_valid/out_ready/flush to either ready
    // or valid. A full queue does not accept a push even when popping.
    assign in_ready  = (count_q != FULL_COUNT);
    assign out_valid = (count_q != '0);

    // Flush overrides both handshakes: the presented tuple is dropped and
    // the head is not consumed.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wp      <= '0;
            rp      <= '0;
            count_q <= '0;
        end else if (flush) begin
            wp      <= '0;
            rp      <= '0;
            count_q <= '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so the increment wraps
            // from DEPTH-1 to 0 on its own.
            if (push) wp <= wp + PTR_W'(1);
            if (pop)  rp <= rp + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read
    // after it has been written, and leaving it unreset lets it map to
    // plain registers or distributed RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wp] <= '{pc:         in_pc,
                             instr:      in_instr,
                             pred_pc:    in_pred_pc,
                             pred_taken: in_pred_taken};
        end
    end

    // First-word fall-through: the head is read straight from storage.
    // A tuple pushed into an empty queue becomes visible one edge later.
    assign head           = entries[rp];
    assign out_pc         = head.pc;
    assign out_instr      = head.instr;
    assign out_pred_pc    = head.pred_pc;
    assign out_pred_taken = head.pred_taken;

    // Compressed/invalid encodings are delivered normally; decode traps.
    assign out_illegal    = (head.instr[1:0] != 2'b11);

    assign count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Self-checking bench for fetch_queue. A queue of tuples is the reference
// model: push/pop/flush rules are applied to it once per rising edge, and
// DUT outputs are compared against it on the falling edge.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 48;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
        logic [PC_W-1:0] pred_pc;
        logic            pred_taken;
    } tuple_t;

    logic             clk;
    logic             n_reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [PC_W-1:0]  in_pc;
    logic [31:0]      in_instr;
    logic [PC_W-1:0]  in_pred_pc;
    logic             in_pred_taken;
    logic             out_valid;
    logic             out_ready;
    logic [PC_W-1:0]  out_pc;
    logic [31:0]      out_instr;
    logic [PC_W-1:0]  out_pred_pc;
    logic             out_pred_taken;
    logic             out_illegal;
    logic [CNT_W-1:0] count;

    int     checks = 0;
    int     errors = 0;
    tuple_t model_q[$];

    fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_instr       (in_instr),
        .in_pred_pc     (in_pred_pc),
        .in_pred_taken  (in_pred_taken),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_pred_pc    (out_pred_pc),
        .out_pred_taken (out_pred_taken),
        .out_illegal    (out_illegal),
        .count          (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the fetch-side inputs (called on the falling edge).
    task automatic drive_in(input logic v, input logic [PC_W-1:0] pc,
                            input logic [31:0] instr,
                            input logic [PC_W-1:0] pred_pc, input logic taken);
        in_valid      = v;
        in_pc         = pc;
        in_instr      = instr;
        in_pred_pc    = pred_pc;
        in_pred_taken = taken;
    endtask

    // Advance one clock: apply the queue rules to the model at the rising
    // edge using the inputs held stable across it, then return on the
    // falling edge where outputs are sampled.
    task automatic cycle();
        bit     do_push;
        bit     do_pop;
        tuple_t t;
        @(posedge clk);
        do_push = in_valid && (model_q.size() < DEPTH) && !flush;
        do_pop  = (model_q.size() != 0) && out_ready && !flush;
        t.pc         = in_pc;
        t.instr      = in_instr;
        t.pred_pc    = in_pred_pc;
        t.pred_taken = in_pred_taken;
        if (flush) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(t);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_reset   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive_in(1'b0, '0, '0, '0, 1'b0);
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        model_q.delete();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid);
        end
        checks++;
        if (count !== '0) begin
            errors++; $display("FAIL reset_count got %0d exp 0", count);
        end
    endtask

    task automatic test_fill_drain();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_in(1'b1, PC_W'(4 * i), 32'h0000_0013, PC_W'(4 * i + 4), 1'b0);
            cycle();
        end
        checks++;
        if (count !== CNT_W'(DEPTH)) begin
            errors++; $display("FAIL fill_count got %0d exp %0d", count, DEPTH);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL fill_in_ready got %0b exp 0", in_ready);
        end
        drive_in(1'b1, PC_W'(16), 32'h0000_0013, PC_W'(20), 1'b0);
        cycle();
        checks++;
        if (count !== CNT_W'(DEPTH) || out_pc !== PC_W'(0)) begin
            errors++;
            $display("FAIL full_push_ignored got count %0d head %0h exp %0d 0",
                     count, out_pc, DEPTH);
        end
        drive_in(1'b0, '0, '0, '0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== PC_W'(4 * i)) begin
                errors++;
                $display("FAIL drain_order[%0d] got v=%0b pc=%0h exp v=1 pc=%0h",
                         i, out_valid, out_pc, 4 * i);
            end
            cycle();
        end
        checks++;
        if (count !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty got count %0d v %0b exp 0 0", count, out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_streaming();
        logic [PC_W-1:0] pc;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pc = PC_W'(48'h1000 + 4 * i);
            drive_in(1'b1, pc, 32'h0000_0033, pc + PC_W'(4), 1'b0);
            cycle();
            checks++;
            if (count !== CNT_W'(1) || out_valid !== 1'b1 || out_pc !== pc) begin
                errors++;
                $display("FAIL stream[%0d] got count %0d pc %0h exp 1 %0h",
                         i, count, out_pc, pc);
            end
        end
        drive_in(1'b0, '0, '0, '0, 1'b0);
        cycle();
        checks++;
        if (count !== '0) begin
            errors++; $display("FAIL stream_drain got %0d exp 0", count);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_in(1'b1, PC_W'(48'h50 + 4 * i), 32'h0000_0013, '0, 1'b0);
            cycle();
        end
        checks++;
        if (count !== CNT_W'(3)) begin
            errors++; $display("FAIL flush_setup_count got %0d exp 3", count);
        end
        flush     = 1'b1;
        out_ready = 1'b1;
        drive_in(1'b1, PC_W'(48'h100), 32'h0000_0013, PC_W'(48'h104), 1'b0);
        cycle();
        checks++;
        if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_empty got count %0d v %0b r %0b exp 0 0 1",
                     count, out_valid, in_ready);
        end
        flush     = 1'b0;
        out_ready = 1'b0;
        drive_in(1'b1, PC_W'(48'h200), 32'h0000_0013, PC_W'(48'h204), 1'b0);
        cycle();
        drive_in(1'b0, '0, '0, '0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== PC_W'(48'h200) || count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL post_flush_push got v %0b pc %0h count %0d exp 1 200 1",
                     out_valid, out_pc, count);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_illegal();
        out_ready = 1'b0;
        drive_in(1'b1, PC_W'(48'h300), 32'h0000_0013, PC_W'(48'h1000), 1'b1);
        cycle();
        drive_in(1'b1, PC_W'(48'h1000), 32'h0000_4501, PC_W'(48'h2000), 1'b0);
        cycle();
        drive_in(1'b0, '0, '0, '0, 1'b0);
        checks++;
        if (out_illegal !== 1'b0 || out_pred_pc !== PC_W'(48'h1000) ||
            out_pred_taken !== 1'b1) begin
            errors++;
            $display("FAIL illegal_head0 got ill %0b ppc %0h tk %0b exp 0 1000 1",
                     out_illegal, out_pred_pc, out_pred_taken);
        end
        out_ready = 1'b1;
        cycle();
        checks++;
        if (out_illegal !== 1'b1 || out_instr !== 32'h0000_4501 ||
            out_pred_pc !== PC_W'(48'h2000) || out_pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL illegal_head1 got ill %0b ins %0h ppc %0h tk %0b exp 1 4501 2000 0",
                     out_illegal, out_instr, out_pred_pc, out_pred_taken);
        end
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_in(1'b1, PC_W'(48'h400 + 4 * i), 32'h0000_0013, '0, 1'b0);
            cycle();
        end
        drive_in(1'b0, '0, '0, '0, 1'b0);
        checks++;
        if (count !== CNT_W'(2)) begin
            errors++; $display("FAIL async_setup_count got %0d exp 2", count);
        end
        // Assert reset between edges and sample before the next rising edge.
        #2 n_reset = 1'b0;
        #1;
        checks++;
        if (count !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got count %0d v %0b exp 0 0", count, out_valid);
        end
        model_q.delete();
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        tuple_t exp_head;
        for (int i = 0; i < 600; i++) begin
            flush     = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            drive_in($urandom_range(0, 3) != 0,
                     PC_W'({$urandom(), $urandom()}), $urandom(),
                     PC_W'({$urandom(), $urandom()}), 1'($urandom_range(0, 1)));
            cycle();
            checks++;
            if (count !== CNT_W'(model_q.size()) ||
                out_valid !== (model_q.size() != 0) ||
                in_ready !== (model_q.size() != DEPTH)) begin
                errors++;
                $display("FAIL rand_occ[%0d] got count %0d v %0b r %0b exp count %0d",
                         i, count, out_valid, in_ready, model_q.size());
            end
            if (model_q.size() != 0) begin
                exp_head = model_q[0];
                checks++;
                if (out_pc !== exp_head.pc || out_instr !== exp_head.instr ||
                    out_pred_pc !== exp_head.pred_pc ||
                    out_pred_taken !== exp_head.pred_taken ||
                    out_illegal !== (exp_head.instr[1:0] != 2'b11)) begin
                    errors++;
                    $display("FAIL rand_head[%0d] got pc %0h ins %0h ppc %0h tk %0b ill %0b exp pc %0h ins %0h ppc %0h tk %0b",
                             i, out_pc, out_instr, out_pred_pc, out_pred_taken,
                             out_illegal, exp_head.pc, exp_head.instr,
                             exp_head.pred_pc, exp_head.pred_taken);
                end
            end
        end
        flush     = 1'b0;
        out_ready = 1'b0;
        drive_in(1'b0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_streaming();
        test_flush();
        test_illegal();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer between the fetch stage and decode in the RV64IMFD pipeline. Captures each fetched {pc, instruction, predicted next PC, taken flag} tuple and holds it in a small first-word-fall-through FIFO until decode accepts it. This decouples fetch from decode stalls. It is emptied in one cycle on an execute-stage mispredict and flags instruction words that are not 32-bit encodings.

## Interface
- DEPTH, 4, number of entries; power of two, minimum 2
- PC_W, 48, PC width in bits
- clk  input  1  clock, all state updates on rising edge
- n_reset  input  1  reset, asynchronous, active-low
- flush  input  1  mispredict redirect from execute (mispred_ex); discard all contents
- in_valid  input  1  fetch presents a valid tuple
- in_ready  output  1  queue can accept a tuple this cycle
- in_pc  input  PC_W  PC of the fetched instruction
- in_instr  input  32  fetched instruction word
- in_pred_pc  input  PC_W  predictor's next-PC for this instruction
- in_pred_taken  input  1  predictor redirected (pred_pc != pc+4)
- out_valid  output  1  head entry is valid for decode
- out_ready  input  1  decode accepts head this cycle
- out_pc  output  PC_W  head PC
- out_instr  output  32  head instruction
- out_pred_pc  output  PC_W  head predicted next-PC
- out_pred_taken  output  1  head prediction flag
- out_illegal  output  1  head instr[1:0] != 2'b11 (compressed/invalid encoding; C extension not supported)
- count  output  $clog2(DEPTH+1)  current occupancy

## Operation
- Storage: DEPTH-entry circular array. The write pointer (wp) and read pointer (rp) are each log2(DEPTH) bits and wrap modulo DEPTH. count tracks occupancy 0..DEPTH.
- Push: in_valid && in_ready && !flush. Writes the tuple at wp. wp increments.
- Pop: out_valid && out_ready && !flush. rp increments.
- in_ready = (count != DEPTH). It does not depend on out_ready. When full, there is no push-through in the same cycle as a pop.
- out_valid = (count != 0). out_* are driven directly from entry[rp] (first-word fall-through). out_* values are don't-care when out_valid=0.
- out_illegal is computed combinationally from the head entry's instr[1:0]. The entry is still delivered normally; decode raises the trap.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Push when count=0: the entry is not visible on out_* until the next cycle. There is no combinational in→out bypass.
- Flush has priority over push and pop. At the next edge: wp=rp=0 and count=0. The tuple presented that cycle is dropped, and the head is not consumed even if out_ready=1.
- The write pointer wraps from DEPTH-1 to 0; the read pointer wraps the same way. Ordering is strict FIFO across the wrap.
- Reset (asynchronous, any cycle including mid-push or mid-flush): wp=0, rp=0, count=0. Storage contents are not reset.

## Timing
- Reset values: in_ready=1, out_valid=0, count=0. out_pc, out_instr, out_pred_pc, out_pred_taken and out_illegal are don't-care while out_valid=0.
- Latency: push at edge N gives out_valid=1 after edge N; the minimum in→out latency is 1 cycle.
- Throughput: 1 tuple/cycle sustained when 0 < count < DEPTH and both sides are handshaking.
- in_ready and out_valid are functions of registered count only. They have no combinational path from in_valid, out_ready or flush.
- Flush asserted in cycle N: out_valid=0 and count=0 from edge N onward. The first post-flush push (cycle N+1) appears at out in cycle N+2.

## Test plan
- Reset then idle: n_reset low then high, in_valid=0 → in_ready=1, out_valid=0, count=0.
- Fill/drain, DEPTH=4: push pc 0x0, 0x4, 0x8, 0xC with out_ready=0 → count=4, in_ready=0. A fifth push of 0x10 is ignored. Then out_ready=1 for 4 cycles → out_pc 0x0, 0x4, 0x8, 0xC in order, then count=0 and out_valid=0.
- Streaming: continuous push with out_ready=1 over 10 pcs → count stays 1 after the first cycle, out_pc matches input delayed 1 cycle, and the pointers wrap twice without loss.
- Flush with push and pop: count=3, flush=1, in_valid=1 (pc 0x100), out_ready=1 → next cycle count=0 and out_valid=0. Then push pc 0x200 → out_pc=0x200 two cycles after flush.
- Illegal flag: push instr 0x00000013 then 0x00004501 → out_illegal 0 then 1. out_pred_pc and out_pred_taken pass through unchanged (e.g. 0x0000_0000_1000, 1).
- Asynchronous reset mid-stream: assert n_reset low between edges with count=2 → count=0 and out_valid=0 immediately, without waiting for a clock edge.
